// File: rtl/ifu_inst_queue_if.sv
// Fetch-side and decode-side signal bundle for the dual-lane instruction queue.
// The slave modport is the queue; the master modport is the fetch/decode environment.
interface ifu_inst_queue_if #(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned DW    = 32,
  parameter int unsigned AW    = 32
);
  logic                     flush_i;

  logic                     f_inst1_valid_i;
  logic [DW-1:0]            f_inst1_i;
  logic [AW-1:0]            f_inst1_addr_i;
  logic                     f_pred1_i;
  logic                     f_inst2_valid_i;
  logic [DW-1:0]            f_inst2_i;
  logic [AW-1:0]            f_inst2_addr_i;
  logic                     f_pred2_i;
  logic                     fetch_ready_o;

  logic [DW-1:0]            inst_o;
  logic [AW-1:0]            inst_addr_o;
  logic                     is_pred_branch_o;
  logic                     inst_valid_o;
  logic [DW-1:0]            inst2_o;
  logic [AW-1:0]            inst2_addr_o;
  logic                     is_pred_branch2_o;
  logic                     inst2_valid_o;
  logic                     accept1_i;
  logic                     accept2_i;

  logic [$clog2(DEPTH):0]   count_o;

  modport slave (
    input  flush_i,
    input  f_inst1_valid_i, f_inst1_i, f_inst1_addr_i, f_pred1_i,
    input  f_inst2_valid_i, f_inst2_i, f_inst2_addr_i, f_pred2_i,
    output fetch_ready_o,
    output inst_o, inst_addr_o, is_pred_branch_o, inst_valid_o,
    output inst2_o, inst2_addr_o, is_pred_branch2_o, inst2_valid_o,
    input  accept1_i, accept2_i,
    output count_o
  );

  modport master (
    output flush_i,
    output f_inst1_valid_i, f_inst1_i, f_inst1_addr_i, f_pred1_i,
    output f_inst2_valid_i, f_inst2_i, f_inst2_addr_i, f_pred2_i,
    input  fetch_ready_o,
    input  inst_o, inst_addr_o, is_pred_branch_o, inst_valid_o,
    input  inst2_o, inst2_addr_o, is_pred_branch2_o, inst2_valid_o,
    output accept1_i, accept2_i,
    input  count_o
  );
endinterface

// File: rtl/ifu_inst_queue.sv
// Dual-lane in-order instruction queue: up to two enqueues and two retires per cycle,
// presenting the two oldest entries to decode. All outputs are functions of registers only.
module ifu_inst_queue #(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned DW    = 32,
  parameter int unsigned AW    = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  ifu_inst_queue_if.slave q
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  logic [DW-1:0] inst_mem_q [DEPTH];
  logic [AW-1:0] addr_mem_q [DEPTH];
  logic          pred_mem_q [DEPTH];

  logic [PW-1:0] rd_ptr_q, rd_ptr_d, rd_ptr_nx;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d, wr_ptr_nx;
  logic [CW-1:0] count_q, count_d;

  logic          lane1_valid;
  logic          lane2_valid;
  logic          ready;
  logic [1:0]    push_n;
  logic [1:0]    pop_n;

  assign rd_ptr_nx = rd_ptr_q + PW'(1);
  assign wr_ptr_nx = wr_ptr_q + PW'(1);

  // Readiness uses the registered count only, so there is no path from accept to fetch.
  always_comb begin
    lane1_valid = (count_q != '0);
    lane2_valid = (count_q >= CW'(2));
    ready       = (count_q <= CW'(DEPTH - 2));

    pop_n = 2'd0;
    if (q.accept1_i && lane1_valid) begin
      pop_n = (q.accept2_i && lane2_valid) ? 2'd2 : 2'd1;
    end

    push_n = 2'd0;
    if (ready && q.f_inst1_valid_i) begin
      push_n = q.f_inst2_valid_i ? 2'd2 : 2'd1;
    end
  end

  always_comb begin
    rd_ptr_d = rd_ptr_q + PW'(pop_n);
    wr_ptr_d = wr_ptr_q + PW'(push_n);
    count_d  = count_q + CW'(push_n) - CW'(pop_n);
    if (q.flush_i) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage is never cleared; stale entries are unreachable once the pointers reset.
  always_ff @(posedge clk) begin
    if (rst_n && !q.flush_i && (push_n != 2'd0)) begin
      inst_mem_q[wr_ptr_q] <= q.f_inst1_i;
      addr_mem_q[wr_ptr_q] <= q.f_inst1_addr_i;
      pred_mem_q[wr_ptr_q] <= q.f_pred1_i;
      if (push_n == 2'd2) begin
        inst_mem_q[wr_ptr_nx] <= q.f_inst2_i;
        addr_mem_q[wr_ptr_nx] <= q.f_inst2_addr_i;
        pred_mem_q[wr_ptr_nx] <= q.f_pred2_i;
      end
    end
  end

  assign q.fetch_ready_o = ready;
  assign q.count_o       = count_q;

  assign q.inst_valid_o     = lane1_valid;
  assign q.inst_o           = lane1_valid ? inst_mem_q[rd_ptr_q] : '0;
  assign q.inst_addr_o      = lane1_valid ? addr_mem_q[rd_ptr_q] : '0;
  assign q.is_pred_branch_o = lane1_valid ? pred_mem_q[rd_ptr_q] : 1'b0;

  assign q.inst2_valid_o     = lane2_valid;
  assign q.inst2_o           = lane2_valid ? inst_mem_q[rd_ptr_nx] : '0;
  assign q.inst2_addr_o      = lane2_valid ? addr_mem_q[rd_ptr_nx] : '0;
  assign q.is_pred_branch2_o = lane2_valid ? pred_mem_q[rd_ptr_nx] : 1'b0;

endmodule

// File: tb/tb_ifu_inst_queue.sv
// Randomized scoreboard bench for ifu_inst_queue: the driver enqueues expected entries into a
// program-order queue; the monitor compares the presented lanes and retires them on accept.
module tb_ifu_inst_queue;

  localparam int unsigned DEPTH = 8;
  localparam int unsigned DW    = 32;
  localparam int unsigned AW    = 32;
  localparam int          NCYC  = 2000;

  typedef struct packed {
    logic [DW-1:0] inst;
    logic [AW-1:0] addr;
    logic          pred;
  } ent_t;

  logic clk = 1'b0;
  logic rst_n;
  logic started = 1'b0;

  int errors = 0;
  int checks = 0;

  ent_t exp_q[$];

  always #5 clk = ~clk;

  ifu_inst_queue_if #(.DEPTH(DEPTH), .DW(DW), .AW(AW)) qif ();

  ifu_inst_queue #(.DEPTH(DEPTH), .DW(DW), .AW(AW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .q     (qif)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  // Monitor: samples between the input drive (negedge) and the next active edge.
  initial begin
    forever begin
      @(negedge clk);
      #2;
      if (started) begin
        int   n;
        ent_t e1;
        ent_t e2;
        n  = exp_q.size();
        e1 = (n >= 1) ? exp_q[0] : '0;
        e2 = (n >= 2) ? exp_q[1] : '0;
        chk("count",       64'(qif.count_o),          64'(n));
        chk("fetch_ready", 64'(qif.fetch_ready_o),    64'(DEPTH - n >= 2));
        chk("lane1_valid", 64'(qif.inst_valid_o),     64'(n >= 1));
        chk("lane2_valid", 64'(qif.inst2_valid_o),    64'(n >= 2));
        chk("lane1_inst",  64'(qif.inst_o),           64'(e1.inst));
        chk("lane1_addr",  64'(qif.inst_addr_o),      64'(e1.addr));
        chk("lane1_pred",  64'(qif.is_pred_branch_o), 64'(e1.pred));
        chk("lane2_inst",  64'(qif.inst2_o),          64'(e2.inst));
        chk("lane2_addr",  64'(qif.inst2_addr_o),     64'(e2.addr));
        chk("lane2_pred",  64'(qif.is_pred_branch2_o), 64'(e2.pred));
        if (qif.accept1_i && n >= 1) begin
          void'(exp_q.pop_front());
          if (qif.accept2_i && n >= 2) void'(exp_q.pop_front());
        end
      end
    end
  end

  // Driver: phases bias the traffic toward fill, drain, steady dual flow and flush/reset.
  initial begin
    logic [AW-1:0] pc;
    pc = 32'h100;
    rst_n               = 1'b0;
    qif.flush_i         = 1'b0;
    qif.f_inst1_valid_i = 1'b0;
    qif.f_inst1_i       = '0;
    qif.f_inst1_addr_i  = '0;
    qif.f_pred1_i       = 1'b0;
    qif.f_inst2_valid_i = 1'b0;
    qif.f_inst2_i       = '0;
    qif.f_inst2_addr_i  = '0;
    qif.f_pred2_i       = 1'b0;
    qif.accept1_i       = 1'b0;
    qif.accept2_i       = 1'b0;
    repeat (2) @(negedge clk);
    rst_n   = 1'b1;
    started = 1'b1;

    for (int cyc = 0; cyc < NCYC; cyc++) begin
      int   mode;
      bit   ready_m;
      ent_t n1;
      ent_t n2;
      @(negedge clk);
      mode    = (cyc / 100) % 5;
      ready_m = (DEPTH - exp_q.size() >= 2);

      n1 = '{inst: $urandom, addr: pc,       pred: 1'($urandom_range(0, 1))};
      n2 = '{inst: $urandom, addr: pc + 'd4, pred: 1'($urandom_range(0, 1))};
      pc = pc + 'd8;
      qif.f_inst1_i      = n1.inst;
      qif.f_inst1_addr_i = n1.addr;
      qif.f_pred1_i      = n1.pred;
      qif.f_inst2_i      = n2.inst;
      qif.f_inst2_addr_i = n2.addr;
      qif.f_pred2_i      = n2.pred;

      rst_n       = 1'b1;
      qif.flush_i = 1'b0;
      unique case (mode)
        1: begin
          qif.f_inst1_valid_i = 1'b1;
          qif.f_inst2_valid_i = 1'b1;
          qif.accept1_i       = ($urandom_range(0, 7) == 0);
          qif.accept2_i       = 1'($urandom_range(0, 1));
        end
        2: begin
          qif.f_inst1_valid_i = ($urandom_range(0, 5) == 0);
          qif.f_inst2_valid_i = 1'($urandom_range(0, 1));
          qif.accept1_i       = 1'($urandom_range(0, 1));
          qif.accept2_i       = ($urandom_range(0, 3) == 0);
        end
        3: begin
          qif.f_inst1_valid_i = 1'b1;
          qif.f_inst2_valid_i = 1'b1;
          qif.accept1_i       = 1'b1;
          qif.accept2_i       = 1'b1;
        end
        default: begin
          qif.f_inst1_valid_i = 1'($urandom_range(0, 1));
          qif.f_inst2_valid_i = 1'($urandom_range(0, 1));
          qif.accept1_i       = 1'($urandom_range(0, 1));
          qif.accept2_i       = 1'($urandom_range(0, 1));
          qif.flush_i         = ($urandom_range(0, (mode == 4) ? 15 : 39) == 0);
          rst_n               = (mode == 4) || ($urandom_range(0, 59) != 0);
        end
      endcase

      // Commit after the monitor's pops for this cycle, before the active edge.
      #4;
      if (!rst_n || qif.flush_i) begin
        exp_q.delete();
      end else if (ready_m && qif.f_inst1_valid_i) begin
        exp_q.push_back(n1);
        if (qif.f_inst2_valid_i) exp_q.push_back(n2);
      end
    end

    @(negedge clk);
    #4;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/ifu_inst_queue.md
# ifu_inst_queue

Dual-lane instruction queue between the fetch unit and the dual decode stage. It buffers up to DEPTH fetched instructions, each with its address and predicted-branch flag. Every cycle it presents the two oldest entries to the decoder as lane 1 and lane 2. It accepts 0–2 instructions per cycle from fetch and retires 0–2 per cycle on decoder acceptance, in strict program order.

## Interface
Parameters:
- DEPTH, 8, number of instruction entries; power of 2, ≥4
- DW, 32, instruction width
- AW, 32, instruction address width

Ports:
- clk  in  1  clock
- rst_n  in  1  reset; one clock, synchronous, active-low
- flush_i  in  1  discard all entries (redirect or exception)
- f_inst1_valid_i  in  1  fetch lane 1 carries an instruction
- f_inst1_i  in  DW  fetch lane 1 instruction
- f_inst1_addr_i  in  AW  fetch lane 1 address
- f_pred1_i  in  1  fetch lane 1 predicted-branch flag
- f_inst2_valid_i  in  1  fetch lane 2 carries an instruction; meaningful only with f_inst1_valid_i
- f_inst2_i  in  DW  fetch lane 2 instruction
- f_inst2_addr_i  in  AW  fetch lane 2 address
- f_pred2_i  in  1  fetch lane 2 predicted-branch flag
- fetch_ready_o  out  1  queue can take two instructions this cycle
- inst_o, inst_addr_o, is_pred_branch_o  out  DW/AW/1  oldest entry (to decode lane 1)
- inst_valid_o  out  1  lane 1 output valid
- inst2_o, inst2_addr_o, is_pred_branch2_o  out  DW/AW/1  second-oldest entry (to decode lane 2)
- inst2_valid_o  out  1  lane 2 output valid
- accept1_i  in  1  decoder consumes lane 1 this cycle
- accept2_i  in  1  decoder consumes lane 2 this cycle; ignored unless accept1_i
- count_o  out  $clog2(DEPTH)+1  current occupancy (registered)

## Operation
- Storage is a circular buffer with read pointer rd_ptr, write pointer wr_ptr (both $clog2(DEPTH) bits, natural wrap) and count.
- Outputs:
  - inst_valid_o = (count ≥ 1); inst2_valid_o = (count ≥ 2).
  - Lane 1 data comes from entry rd_ptr; lane 2 data from entry rd_ptr+1 (mod DEPTH).
  - A data/addr/pred output whose valid is 0 is driven to 0.
- Pop:
  - pop_n = (accept1_i & inst_valid_o) + (accept1_i & accept2_i & inst2_valid_o).
  - Accept on an invalid lane is ignored. accept2_i without accept1_i pops nothing.
- Push:
  - fetch_ready_o = (DEPTH − count ≥ 2), computed from the registered count only (no same-cycle pop credit).
  - push_n = 0 if !fetch_ready_o, otherwise f_inst1_valid_i + (f_inst1_valid_i & f_inst2_valid_i).
  - Lane 1 is written to wr_ptr and lane 2 to wr_ptr+1. f_inst2_valid_i without f_inst1_valid_i writes nothing.
- Update each cycle:
  - rd_ptr += pop_n, wr_ptr += push_n, count += push_n − pop_n.
  - Simultaneous push and pop are always legal. count never exceeds DEPTH or drops below 0.
- Flush: flush_i has priority over push and pop. Next cycle rd_ptr = wr_ptr = 0 and count = 0. Fetch data offered in the flush cycle is dropped. Entry storage is not cleared.
- Reset (rst_n=0 at a clk edge): identical to flush.
  - After reset: all valid outputs 0, all data outputs 0, fetch_ready_o 1, count_o 0.
  - Reset asserted mid-operation discards all contents.

## Timing
- Enqueue latency 1: an instruction written at edge N appears on outputs after edge N, including when the queue was empty. There is no bypass from fetch inputs to outputs.
- Retire takes effect at the edge. The next entry appears on lane 1 in the following cycle, so back-to-back dual retire sustains 2 instructions/cycle.
- All outputs depend only on registers. fetch_ready_o has no combinational path from accept or fetch inputs.
- Wrap-around: a pointer at DEPTH−1 plus 1 yields 0. A lane 2 write or read straddling the wrap uses entry 0.

## Test plan
- Reset then push {A@0x100, B@0x104} in one cycle with no accept -> next cycle inst_valid_o=1 with inst_o=A, inst2_valid_o=1 with inst2_o=B, count_o=2.
- Fill DEPTH=8 with 4 dual pushes and no accepts -> fetch_ready_o=0 at count 8. A fifth push attempt leaves count at 8 and contents unchanged. A single accept1 gives count 7; fetch_ready_o stays 0 until count ≤6.
- count=1 with accept1_i=accept2_i=1 -> only 1 popped, count_o=0, inst2_valid_o was 0 throughout.
- Steady state: dual push and dual accept every cycle for 20 cycles starting at rd_ptr=7 -> count stays constant, program order preserved across the wrap, addresses strictly increase by 4.
- count=5 with flush_i=1 together with a fetch push and accept1_i -> next cycle count_o=0, both valids 0, outputs 0, fetch_ready_o=1.
- rst_n pulled low for one edge while count=6 -> same result as flush. The first push after reset appears on lane 1 one cycle later.
